// File: rtl/if_id_buf.sv
// Two-entry instruction buffer between fetch and decode.
// Decode sees the head entry one cycle after it is accepted; flush and reset empty the buffer.
module if_id_buf #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        inst_valid_i,
    output logic        inst_ready_o,
    input  logic        hold_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic [1:0]  count_o
);

    logic [31:0] inst_mem [2];
    logic [31:0] addr_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    // ready and valid come from registered occupancy only, never from hold/flush
    assign inst_ready_o = (count != 2'd2);
    assign inst_valid_o = (count != 2'd0);
    assign count_o      = count;

    assign push = inst_valid_i && inst_ready_o && !flush_i;
    assign pop  = inst_valid_o && !hold_i && !flush_i;

    always_comb begin
        inst_o      = NOP_INST;
        inst_addr_o = RST_ADDR;
        if (inst_valid_o) begin
            inst_o      = inst_mem[rd_ptr];
            inst_addr_o = addr_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            inst_mem[wr_ptr] <= inst_i;
            addr_mem[wr_ptr] <= inst_addr_i;
        end
    end

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer's occupancy and ordering.
module tb_if_id_buf;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RSTA = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        inst_valid_i;
    logic        inst_ready_o;
    logic        hold_i;
    logic        flush_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic [1:0]  count_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] q[$];

    if_id_buf dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .inst_valid_i (inst_valid_i),
        .inst_ready_o (inst_ready_o),
        .hold_i       (hold_i),
        .flush_i      (flush_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] ei;
        logic [31:0] ea;
        ei = NOP;
        ea = RSTA;
        if (q.size() != 0) begin
            ei = q[0][63:32];
            ea = q[0][31:0];
        end
        check({tag, "_valid"}, inst_valid_o, (q.size() != 0));
        check({tag, "_ready"}, inst_ready_o, (q.size() < 2));
        check({tag, "_count"}, count_o, q.size());
        check({tag, "_inst"},  inst_o, ei);
        check({tag, "_addr"},  inst_addr_o, ea);
    endtask

    // One clock: check current outputs, drive inputs, advance the model, clock.
    task automatic step(input string tag, input bit r, input bit f, input bit v,
                        input bit h, input logic [31:0] i, input logic [31:0] a);
        bit do_push;
        bit do_pop;
        if (!rst) check_model(tag);
        rst          = r;
        flush_i      = f;
        inst_valid_i = v;
        hold_i       = h;
        inst_i       = i;
        inst_addr_i  = a;
        if (r || f) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && !h;
            do_push = v && (q.size() < 2);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({i, a});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, inst_valid_o, 1'b0);
        check({tag, "_ready"}, inst_ready_o, 1'b1);
        check({tag, "_count"}, count_o, 2'd0);
        check({tag, "_inst"},  inst_o, NOP);
        check({tag, "_addr"},  inst_addr_o, RSTA);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0; hold_i = 1'b0;
        inst_i = '0; inst_addr_i = '0;
        step("rst", 1, 0, 0, 0, 0, 0);
        step("rst", 1, 0, 1, 0, 32'hDEAD_BEEF, 32'h4);
        rst = 1'b0;
        check_empty("reset");

        // pass-through
        step("pt0", 0, 0, 1, 0, 32'h0050_0093, 32'h4);
        check("pt_inst", inst_o, 32'h0050_0093);
        check("pt_addr", inst_addr_o, 32'h4);
        check("pt_valid", inst_valid_o, 1'b1);
        step("pt1", 0, 0, 0, 0, 0, 0);
        check("pt_drain_valid", inst_valid_o, 1'b0);
        check("pt_drain_inst", inst_o, NOP);

        // fill under hold, third push ignored, release drains in order
        step("fh0", 0, 0, 1, 1, 32'hAAAA_0001, 32'h8);
        step("fh1", 0, 0, 1, 1, 32'hBBBB_0002, 32'hC);
        check("fh_count", count_o, 2'd2);
        check("fh_ready", inst_ready_o, 1'b0);
        check("fh_head", inst_o, 32'hAAAA_0001);
        step("fh2", 0, 0, 1, 1, 32'hCCCC_0003, 32'h30);
        check("fh_ignored_count", count_o, 2'd2);
        check("fh_ignored_head", inst_o, 32'hAAAA_0001);
        step("fh3", 0, 0, 0, 0, 0, 0);
        check("fh_second", inst_o, 32'hBBBB_0002);
        check("fh_second_addr", inst_addr_o, 32'hC);
        step("fh4", 0, 0, 0, 0, 0, 0);
        check("fh_done", count_o, 2'd0);

        // simultaneous push/pop at count 1
        step("pp0", 0, 0, 1, 0, 32'hAAAA_0001, 32'h8);
        step("pp1", 0, 0, 1, 0, 32'hCCCC_0004, 32'h10);
        check("pp_count", count_o, 2'd1);
        check("pp_head", inst_o, 32'hCCCC_0004);
        check("pp_addr", inst_addr_o, 32'h10);
        step("pp2", 0, 0, 0, 0, 0, 0);

        // flush beats push/pop/hold
        step("fl0", 0, 0, 1, 1, 32'h1111_0001, 32'h14);
        step("fl1", 0, 0, 1, 1, 32'h2222_0002, 32'h18);
        step("fl2", 0, 1, 1, 0, 32'hDDDD_0005, 32'h40);
        check_empty("flush");
        step("fl3", 0, 0, 0, 0, 0, 0);
        check_empty("flush_noD");

        // reset beats flush and push, then a fresh push is alone at head
        step("rs0", 0, 0, 1, 1, 32'h3333_0001, 32'h1C);
        step("rs1", 0, 0, 1, 1, 32'h4444_0002, 32'h24);
        step("rs2", 1, 1, 1, 0, 32'h5555_0003, 32'h28);
        rst = 1'b0;
        check_empty("midrst");
        step("rs3", 0, 0, 1, 1, 32'hEEEE_0006, 32'h20);
        check("rs_head", inst_o, 32'hEEEE_0006);
        check("rs_addr", inst_addr_o, 32'h20);
        check("rs_count", count_o, 2'd1);
        step("rs4", 0, 0, 0, 0, 0, 0);

        // wrap-around: back-to-back push/pop
        for (int k = 0; k < 5; k++) begin
            step("wrap", 0, 0, 1, 0, 32'h9000_0000 + k, 32'h100 + 4 * k);
            check("wrap_head", inst_o, 32'h9000_0000 + k);
            check("wrap_cnt_le1", (count_o <= 2'd1), 1'b1);
        end
        step("wrap_end", 0, 0, 0, 0, 0, 0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            step("rnd",
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0),
                 $urandom, $urandom);
            rst = 1'b0;
        end
        check_model("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 SHALL provide parameter NOP_INST, default 32'h0000_0013, instruction presented when the buffer is empty (addi x0,x0,0).
REQ-002 SHALL provide parameter RST_ADDR, default 32'h0000_0000, address presented when the buffer is empty.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port inst_i  input  32  fetched instruction.
REQ-006 SHALL provide port inst_addr_i  input  32  address of inst_i.
REQ-007 SHALL provide port inst_valid_i  input  1  inst_i/inst_addr_i valid this cycle.
REQ-008 SHALL provide port inst_ready_o  output  1  buffer can accept this cycle.
REQ-009 SHALL provide port hold_i  input  1  decode stall; head entry is not consumed.
REQ-010 SHALL provide port flush_i  input  1  branch/jump redirect; discard all buffered entries.
REQ-011 SHALL provide port inst_o  output  32  head instruction to decode.
REQ-012 SHALL provide port inst_addr_o  output  32  head instruction address to decode.
REQ-013 SHALL provide port inst_valid_o  output  1  inst_o/inst_addr_o hold a real instruction.
REQ-014 SHALL provide port count_o  output  2  occupancy, 0..2.

Function
REQ-015 SHALL implement a 2-entry FIFO: 1-bit write pointer, 1-bit read pointer, 2-bit count, each pointer wrapping 1->0.
REQ-016 SHALL drive inst_ready_o = (count != 2), from registered state only; no combinational path from hold_i or flush_i.
REQ-017 SHALL push {inst_i, inst_addr_i} at wr_ptr and advance wr_ptr when inst_valid_i && inst_ready_o && !flush_i.
REQ-018 SHALL drive inst_valid_o = (count != 0).
REQ-019 SHALL present the entry at rd_ptr on inst_o/inst_addr_o when count != 0; when count == 0, SHALL present NOP_INST and RST_ADDR.
REQ-020 SHALL pop (advance rd_ptr) when inst_valid_o && !hold_i && !flush_i.
REQ-021 SHALL update count: push only +1, pop only -1, push and pop together unchanged.
REQ-022 SHALL have exactly 1-cycle latency: an entry accepted on edge N is visible at the outputs after edge N when the buffer was empty; there is no input-to-output bypass.
REQ-023 Full (count=2) with pop in the same cycle: SHALL NOT accept (ready already 0); count becomes 1.
REQ-024 Empty with hold_i=1: SHALL still accept a push; count becomes 1.
REQ-025 SHALL give flush_i priority over push, pop and hold. After the edge: count=0, wr_ptr=rd_ptr=0, and any push offered in the flush cycle is dropped.
REQ-026 In the flush cycle, outputs SHALL reflect pre-flush state. Downstream discards them.
REQ-027 SHALL leave stored entry contents unchanged on flush or pop; only pointers and count change.

Reset
REQ-028 On rst=1 at a rising edge, SHALL set count=0, wr_ptr=0, rd_ptr=0. rst SHALL take priority over flush_i and all handshakes.
REQ-029 After reset, outputs SHALL be: inst_valid_o=0, inst_ready_o=1, count_o=0, inst_o=NOP_INST, inst_addr_o=RST_ADDR.
REQ-030 Reset mid-operation with entries held: all entries discarded, and outputs per REQ-029 on the next cycle.
REQ-031 Storage arrays need no reset.

Verification
REQ-032 Pass-through: push 32'h0050_0093 @ 32'h0000_0004, hold_i=0 -> next cycle inst_o=32'h0050_0093, inst_addr_o=4, valid=1; following cycle valid=0, inst_o=32'h13.
REQ-033 Fill under hold: hold_i=1, push A@0x8 then B@0xC -> count_o=2, ready=0, inst_o=A. A third push is ignored. Release hold -> A, then B, in order.
REQ-034 Simultaneous push/pop at count=1: push C@0x10 while A is popped -> count_o stays 1, head becomes C.
REQ-035 Flush priority: count=2, flush_i=1 with valid push D and hold_i=0 -> next cycle count_o=0, valid=0, inst_o=32'h13, D is absent.
REQ-036 Reset mid-stream: count=2, rst=1 together with flush_i=1 and a push -> next cycle outputs per REQ-029. A subsequent push E@0x20 appears alone at the head.
REQ-037 Wrap-around: 5 push/pop cycles back-to-back -> all 5 instructions emerge in order and count_o never exceeds 1.
